// File: rtl/voice_table_arbiter_pkg.sv
// voice_arb_pkg: shared types and helpers for the voice-table arbiter.
// Holds the slot-owner and FSM state encodings and the voice-index width helper.
package voice_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_MIDI,
        OWN_SCAN
    } owner_e;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_e;

    // Width of a voice index; a single-voice table still needs one bit.
    function automatic int voiceWidth(input int numVoices);
        return (numVoices > 1) ? $clog2(numVoices) : 1;
    endfunction

endpackage

// File: rtl/voice_table_arbiter_if.sv
// voice_table_arbiter_if: MIDI request/grant/read-return bus plus the RAM port pins.
// The arbiter connects through the slave modport; the MIDI handler and the RAM
// model sit on the master side.
interface voice_table_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  midi_req;
    logic                  midi_we;
    logic [ADDR_WIDTH-1:0] midi_addr;
    logic [DATA_WIDTH-1:0] midi_wdata;
    logic                  midi_gnt;
    logic                  midi_rvalid;
    logic [DATA_WIDTH-1:0] midi_rdata;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  midi_req, midi_we, midi_addr, midi_wdata, ram_dout,
        output midi_gnt, midi_rvalid, midi_rdata, ram_addr, ram_we, ram_din
    );

    modport master (
        output midi_req, midi_we, midi_addr, midi_wdata, ram_dout,
        input  midi_gnt, midi_rvalid, midi_rdata, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/voice_arb_tagpipe.sv
// voice_arb_tagpipe: one-stage delay of the issue tag (owner, voice index, last flag)
// so that it lines up with ram_dout, which returns one cycle after the address.
module voice_arb_tagpipe
    import voice_arb_pkg::*;
#(
    parameter int VOICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  owner_e             owner_i,
    input  logic [VOICE_W-1:0] voice_i,
    input  logic               last_i,
    output owner_e             owner_o,
    output logic [VOICE_W-1:0] voice_o,
    output logic               last_o
);

    owner_e             owner_q;
    logic [VOICE_W-1:0] voice_q;
    logic               last_q;

    // Delay the tag by one cycle; reset drops any in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            voice_q <= '0;
            last_q  <= 1'b0;
        end else begin
            owner_q <= owner_i;
            voice_q <= voice_i;
            last_q  <= last_i;
        end
    end

    assign owner_o = owner_q;
    assign voice_o = voice_q;
    assign last_o  = last_q;

endmodule

// File: rtl/voice_table_arbiter.sv
// voice_table_arbiter: shares one voice-parameter RAM port between the per-tick
// voice scanner (priority) and the MIDI note handler (bounded wait).
// Optional build macro VOICE_ARB_OVERRUN_EN adds a sticky overrun flag for
// sample ticks that arrive while a sweep is still running.
module voice_table_arbiter
    import voice_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_VOICES = 16,
    parameter logic [ADDR_WIDTH-1:0] SCAN_BASE  = '0,
    parameter int                    MAX_WAIT   = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    voice_table_arbiter_if.slave                bus,
    input  logic                                sample_tick_i,
    output logic                                scan_valid_o,
    output logic [voiceWidth(NUM_VOICES)-1:0]   scan_voice_o,
    output logic [DATA_WIDTH-1:0]               scan_data_o,
    output logic                                scan_done_o,
    output logic                                busy_o
`ifdef VOICE_ARB_OVERRUN_EN
    ,
    output logic                                overrun_o,
    input  logic                                overrun_clr_i
`endif
);

    localparam int              VW       = voiceWidth(NUM_VOICES);
    localparam int              WW       = $clog2(MAX_WAIT + 1);
    localparam logic [VW-1:0]   LAST_IDX = VW'(NUM_VOICES - 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

    state_e                state_q, state_d;
    logic [VW-1:0]         idx_q, idx_d;
    logic [WW-1:0]         wait_q, wait_d;
    owner_e                owner;
    logic                  midiElig;

    logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic                  ramWe_q, ramWe_d;
    logic [DATA_WIDTH-1:0] ramDin_q, ramDin_d;
    logic                  gnt_q, gnt_d;
    owner_e                issueOwner_q, issueOwner_d;
    logic [VW-1:0]         issueVoice_q, issueVoice_d;
    logic                  issueLast_q, issueLast_d;

    owner_e                tagOwner;
    logic [VW-1:0]         tagVoice;
    logic                  tagLast;

    // Slot decision and FSM next state: scanner wins unless MIDI has waited long enough.
    always_comb begin
        midiElig = bus.midi_req && !gnt_q;
        owner    = OWN_NONE;
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (midiElig) begin
                    owner = OWN_MIDI;
                end
                if (sample_tick_i) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (midiElig && (wait_q == WAIT_MAX)) begin
                    owner  = OWN_MIDI;
                    wait_d = '0;
                end else begin
                    owner  = OWN_SCAN;
                    wait_d = midiElig ? wait_q + 1'b1 : '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM pin, grant and issue-tag next values for whichever requester owns the slot.
    always_comb begin
        ramAddr_d    = ramAddr_q;
        ramWe_d      = 1'b0;
        ramDin_d     = ramDin_q;
        gnt_d        = 1'b0;
        issueOwner_d = OWN_NONE;
        issueVoice_d = idx_q;
        issueLast_d  = 1'b0;
        unique case (owner)
            OWN_MIDI: begin
                ramAddr_d    = bus.midi_addr;
                ramWe_d      = bus.midi_we;
                ramDin_d     = bus.midi_wdata;
                gnt_d        = 1'b1;
                issueOwner_d = bus.midi_we ? OWN_NONE : OWN_MIDI;
            end
            OWN_SCAN: begin
                ramAddr_d    = SCAN_BASE + ADDR_WIDTH'(idx_q);
                issueOwner_d = OWN_SCAN;
                issueLast_d  = (idx_q == LAST_IDX);
            end
            default: begin
            end
        endcase
    end

    // State, counters, registered RAM pins and issue tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            ramAddr_q    <= '0;
            ramWe_q      <= 1'b0;
            ramDin_q     <= '0;
            gnt_q        <= 1'b0;
            issueOwner_q <= OWN_NONE;
            issueVoice_q <= '0;
            issueLast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            ramAddr_q    <= ramAddr_d;
            ramWe_q      <= ramWe_d;
            ramDin_q     <= ramDin_d;
            gnt_q        <= gnt_d;
            issueOwner_q <= issueOwner_d;
            issueVoice_q <= issueVoice_d;
            issueLast_q  <= issueLast_d;
        end
    end

    voice_arb_tagpipe #(
        .VOICE_W (VW)
    ) u_tagpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .owner_i (issueOwner_q),
        .voice_i (issueVoice_q),
        .last_i  (issueLast_q),
        .owner_o (tagOwner),
        .voice_o (tagVoice),
        .last_o  (tagLast)
    );

    assign bus.ram_addr    = ramAddr_q;
    assign bus.ram_we      = ramWe_q;
    assign bus.ram_din     = ramDin_q;
    assign bus.midi_gnt    = gnt_q;
    assign bus.midi_rvalid = (tagOwner == OWN_MIDI);
    assign bus.midi_rdata  = bus.ram_dout;

    assign scan_valid_o = (tagOwner == OWN_SCAN);
    assign scan_voice_o = tagVoice;
    assign scan_data_o  = bus.ram_dout;
    assign scan_done_o  = scan_valid_o && tagLast;
    assign busy_o       = (state_q == ST_SCAN);

`ifdef VOICE_ARB_OVERRUN_EN
    logic overrun_q;

    // Sticky flag for ticks lost to a running sweep; a new loss beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (sample_tick_i && busy_o) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_voice_table_arbiter.sv
// tb_voice_table_arbiter: directed bench with a read-return scoreboard.
// Stimulus pushes expected scan/MIDI returns (with their arrival cycle) into a
// queue; a negedge monitor pops one entry per returned word.
module tb_voice_table_arbiter;
    import voice_arb_pkg::*;

    localparam int         ADDR_WIDTH = 8;
    localparam int         DATA_WIDTH = 32;
    localparam int         NUM_VOICES = 16;
    localparam int         MAX_WAIT   = 4;
    localparam logic [7:0] SCAN_BASE  = 8'h20;
    localparam int         VW         = voiceWidth(NUM_VOICES);

    typedef struct packed {
        logic          isScan;
        logic [VW-1:0] voice;
        logic          done;
        logic [31:0]   data;
        logic [31:0]   cyc;
    } retItem_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          sampleTick;
    logic          scanValid;
    logic [VW-1:0] scanVoice;
    logic [31:0]   scanData;
    logic          scanDone;
    logic          busy;
`ifdef VOICE_ARB_OVERRUN_EN
    logic          overrun;
    logic          overrunClr;
`endif

    int            nCompared   = 0;
    int            nMismatched = 0;
    int unsigned   cycleCount  = 0;
    retItem_t      expQ[$];

    logic [31:0]   mem      [256];
    logic          memValid [256];

    voice_table_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    voice_table_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_VOICES (NUM_VOICES),
        .SCAN_BASE  (SCAN_BASE),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .sample_tick_i (sampleTick),
        .scan_valid_o  (scanValid),
        .scan_voice_o  (scanVoice),
        .scan_data_o   (scanData),
        .scan_done_o   (scanDone),
        .busy_o        (busy)
`ifdef VOICE_ARB_OVERRUN_EN
        ,
        .overrun_o     (overrun),
        .overrun_clr_i (overrunClr)
`endif
    );

    always #5 clk = ~clk;

    // Posedge counter used to time-stamp expected returns.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Registered-read RAM model; unwritten words read as A000_0000 | address.
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]      <= bus.ram_din;
            memValid[bus.ram_addr] <= 1'b1;
        end
        bus.ram_dout <= (memValid[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                          : (32'hA000_0000 | 32'(bus.ram_addr));
    end

    // Scoreboard monitor: every returned word must match the head of the queue.
    always @(negedge clk) begin
        retItem_t got;
        retItem_t exp;
        if (rst_n) begin
            if (scanValid || bus.midi_rvalid) begin
                got.isScan = scanValid;
                got.voice  = scanValid ? scanVoice : '0;
                got.done   = scanDone;
                got.data   = scanValid ? scanData : bus.midi_rdata;
                got.cyc    = cycleCount;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpected_return: got scan=%0b voice=%0d done=%0b data=%h cyc=%0d, required none",
                             got.isScan, got.voice, got.done, got.data, got.cyc);
                end else begin
                    exp = expQ.pop_front();
                    if (got !== exp) begin
                        nMismatched++;
                        $display("[TB] FAIL return: got scan=%0b voice=%0d done=%0b data=%h cyc=%0d, required scan=%0b voice=%0d done=%0b data=%h cyc=%0d",
                                 got.isScan, got.voice, got.done, got.data, got.cyc,
                                 exp.isScan, exp.voice, exp.done, exp.data, exp.cyc);
                    end
                end
            end else if (scanDone) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL done_without_valid: got scan_done=1, required 0 at cyc=%0d", cycleCount);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (cyc=%0d)", name, got, exp, cycleCount);
        end
    endtask

    // Wait for the next negedge and drive the inputs sampled by the following posedge.
    task automatic applyStimulus(input logic tick, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        sampleTick    = tick;
        bus.midi_req  = req;
        bus.midi_we   = we;
        bus.midi_addr = addr;
        bus.midi_wdata = wdata;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic pushMidi(input logic [31:0] data, input int unsigned cyc);
        retItem_t it;
        it.isScan = 1'b0;
        it.voice  = '0;
        it.done   = 1'b0;
        it.data   = data;
        it.cyc    = 32'(cyc);
        expQ.push_back(it);
    endtask

    // Expected sweep returns for a tick driven at cycle base; optional MIDI read
    // forced in after MAX_WAIT scan slots.
    task automatic pushSweep(input int unsigned base, input logic withMidi, input logic [31:0] midiData);
        retItem_t    it;
        int unsigned slip;
        slip = 0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (withMidi && (k == MAX_WAIT)) begin
                pushMidi(midiData, base + 3 + 32'(k));
                slip = 1;
            end
            it.isScan = 1'b1;
            it.voice  = VW'(k);
            it.done   = (k == NUM_VOICES - 1);
            it.data   = 32'hA000_0020 + 32'(k);
            it.cyc    = 32'(base + 3 + 32'(k) + slip);
            expQ.push_back(it);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},      64'(busy),            64'(0));
        checkOutput({tag, "_scanvalid"}, 64'(scanValid),       64'(0));
        checkOutput({tag, "_scandone"},  64'(scanDone),        64'(0));
        checkOutput({tag, "_scanvoice"}, 64'(scanVoice),       64'(0));
        checkOutput({tag, "_gnt"},       64'(bus.midi_gnt),    64'(0));
        checkOutput({tag, "_rvalid"},    64'(bus.midi_rvalid), 64'(0));
        checkOutput({tag, "_ramaddr"},   64'(bus.ram_addr),    64'(0));
        checkOutput({tag, "_ramwe"},     64'(bus.ram_we),      64'(0));
        checkOutput({tag, "_ramdin"},    64'(bus.ram_din),     64'(0));
`ifdef VOICE_ARB_OVERRUN_EN
        checkOutput({tag, "_overrun"},   64'(overrun),         64'(0));
`endif
    endtask

    // One sweep from a tick; optional second tick at sweep cycle tick2At (0 = none).
    task automatic runSweep(input int tick2At);
        int unsigned t;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        t = cycleCount;
        pushSweep(t, 1'b0, 32'h0);
        for (int c = 1; c <= 18; c++) begin
            applyStimulus((tick2At > 0) && (c == tick2At), 1'b0, 1'b0, 8'h00, 32'h0);
`ifdef VOICE_ARB_OVERRUN_EN
            overrunClr = (tick2At > 0) && (c == tick2At + 2);
            checkOutput("overrun", 64'(overrun), 64'((tick2At > 0) && (c > tick2At) && (c <= tick2At + 2)));
`endif
            checkOutput("sweep_busy", 64'(busy), 64'(c <= NUM_VOICES));
            checkOutput("sweep_we", 64'(bus.ram_we), 64'(0));
            if (c >= 2 && c <= NUM_VOICES + 1) begin
                checkOutput("sweep_addr", 64'(bus.ram_addr), 64'(SCAN_BASE + 8'(c - 2)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int unsigned t;
        for (int i = 0; i < 256; i++) memValid[i] = 1'b0;
        sampleTick     = 1'b0;
        bus.midi_req   = 1'b0;
        bus.midi_we    = 1'b0;
        bus.midi_addr  = 8'h00;
        bus.midi_wdata = 32'h0;
`ifdef VOICE_ARB_OVERRUN_EN
        overrunClr     = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] single sweep");
        runSweep(0);

        $display("[TB] idle MIDI write then read");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF);
        t = cycleCount;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("wr_gnt",  64'(bus.midi_gnt), 64'(1));
        checkOutput("wr_we",   64'(bus.ram_we),   64'(1));
        checkOutput("wr_addr", 64'(bus.ram_addr), 64'(8'h05));
        checkOutput("wr_din",  64'(bus.ram_din),  64'(32'hDEAD_BEEF));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
        checkOutput("gap_gnt", 64'(bus.midi_gnt), 64'(0));
        pushMidi(32'hDEAD_BEEF, t + 4);
        idle();
        checkOutput("rd_gnt",  64'(bus.midi_gnt), 64'(1));
        checkOutput("rd_we",   64'(bus.ram_we),   64'(0));
        checkOutput("rd_addr", 64'(bus.ram_addr), 64'(8'h05));
        repeat (3) idle();

        $display("[TB] starvation guard");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        t = cycleCount;
        pushSweep(t, 1'b1, 32'hDEAD_BEEF);
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b0, c <= 5, 1'b0, 8'h05, 32'h0);
            checkOutput("starve_gnt",  64'(bus.midi_gnt), 64'(c == 6));
            checkOutput("starve_busy", 64'(busy),         64'(c <= NUM_VOICES + 1));
            if (c == 5) checkOutput("starve_addr_pre",  64'(bus.ram_addr), 64'(8'h23));
            if (c == 6) checkOutput("starve_addr_midi", 64'(bus.ram_addr), 64'(8'h05));
            if (c == 7) checkOutput("starve_addr_post", 64'(bus.ram_addr), 64'(8'h24));
        end

        $display("[TB] held request in idle");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h21, 32'h0);
        t = cycleCount;
        pushMidi(32'hA000_0021, t + 2);
        pushMidi(32'hA000_0021, t + 4);
        pushMidi(32'hA000_0021, t + 6);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(1'b0, c <= 5, 1'b0, 8'h21, 32'h0);
            checkOutput("held_gnt", 64'(bus.midi_gnt), 64'((c == 1) || (c == 3) || (c == 5)));
        end

        $display("[TB] second tick during sweep");
        runSweep(7);
        repeat (2) idle();

        $display("[TB] tick coincident with MIDI in idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 32'h0);
        t = cycleCount;
        pushMidi(32'hDEAD_BEEF, t + 2);
        pushSweep(t, 1'b0, 32'h0);
        for (int c = 1; c <= 19; c++) begin
            idle();
            if (c == 1) begin
                checkOutput("coinc_gnt",  64'(bus.midi_gnt), 64'(1));
                checkOutput("coinc_addr", 64'(bus.ram_addr), 64'(8'h05));
                checkOutput("coinc_busy", 64'(busy),         64'(1));
            end
            if (c == 2) begin
                checkOutput("coinc_gnt2",  64'(bus.midi_gnt), 64'(0));
                checkOutput("coinc_addr2", 64'(bus.ram_addr), 64'(8'h20));
            end
        end

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        t = cycleCount;
        pushSweep(t, 1'b0, 32'h0);
        for (int c = 1; c <= 5; c++) idle();
        #2 rst_n = 1'b0;
        expQ.delete();
        #1 checkResetOutputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            idle();
            checkOutput("post_reset_busy", 64'(busy), 64'(0));
        end
        runSweep(0);

        repeat (4) idle();
        checkOutput("queue_drained", 64'(expQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
